tug_round_ctrl: RTL

Round sequencer for the Tug of War game. Generates the `leds_on`, `right`, `winrnd` and `tie` inputs of the scorer from the two player pushbuttons. It runs a pseudo-random "get ready" delay, lights the start LED and arbitrates the first push, including jump-the-light and simultaneous pushes. It sits between the button synchronizers and the scorer, and freezes once the scorer reports a game win.

---
 rtl/tug_pkg.sv | 27 ++
 rtl/round_delay_timer.sv | 45 ++++
 rtl/tug_round_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tug_pkg.sv
// Shared types and constants for the Tug of War round sequencer.
package tug_pkg;

    // Round sequencer states; the encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StDelay = 3'd1,
        StLight = 3'd2,
        StScore = 3'd3,
        StHalt  = 3'd4
    } tug_state_e;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
    localparam int unsigned       LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // Scorer LED patterns that mean a player has won the game.
    localparam logic [6:0] WIN_LEFT  = 7'b0000111;
    localparam logic [6:0] WIN_RIGHT = 7'b1110000;

    // Decode of the scorer LED bar into the game_over condition.
    function automatic logic is_win_pattern(input logic [6:0] score_leds);
        return (score_leds == WIN_LEFT) || (score_leds == WIN_RIGHT);
    endfunction

endpackage

// File: rtl/round_delay_timer.sv
// Tick prescaler plus saturating down-counter of ticks.
// load restarts both the prescaler and the count; done flags the edge on
// which the last tick expires, so the caller can change state on that edge.
module round_delay_timer #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             run,
    output logic             done
);

    localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick;

    assign tick = run && (pre_q == PRE_LAST);
    // A zero count also reads as done so a stalled timer can never hang the FSM.
    assign done = run && ((cnt_q == '0) || ((cnt_q == CNT_W'(1)) && tick));

    // Prescaler and tick counter; the count holds at zero rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            pre_q <= '0;
            cnt_q <= load_val;
        end else if (run && (cnt_q != '0)) begin
            if (tick) begin
                pre_q <= '0;
                cnt_q <= cnt_q - CNT_W'(1);
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/tug_round_ctrl.sv
// Tug of War round sequencer: random get-ready delay, start light and
// first-push arbitration feeding the scorer.
// Optional feature macro: TUG_TIMEOUT_EN (LIGHT times out into a tie).
module tug_round_ctrl
    import tug_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned DELAY_MIN     = 8,
    parameter int unsigned DELAY_W       = 4,
    parameter int unsigned TIMEOUT_TICKS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    input  logic       game_over,
    output logic       leds_on,
    output logic       right,
    output logic       winrnd,
    output logic       tie,
    output logic [2:0] state
);

    localparam int unsigned CNT_W = $clog2(DELAY_MIN + (1 << DELAY_W));

    tug_state_e        state_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [CNT_W-1:0]  delay_val;
    logic              delay_load;
    logic              delay_done;
    logic              timeout;
    logic              any_push;
    logic              both_push;

    assign state     = state_q;
    assign any_push  = pbl || pbr;
    assign both_push = pbl && pbr;

    // Free-running LFSR; the nonzero seed and maximal taps keep it off all-zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign delay_val  = CNT_W'(DELAY_MIN) + CNT_W'(lfsr_q[DELAY_W-1:0]);
    // Loading only when both buttons are released stops a held button re-scoring.
    assign delay_load = (state_q == StIdle) && !any_push;

    round_delay_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_delay_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (delay_load),
        .load_val (delay_val),
        .run      (state_q == StDelay),
        .done     (delay_done)
    );

`ifdef TUG_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);

    // Second timer instance counts the LIGHT timeout, armed on entering LIGHT.
    round_delay_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (TO_W)
    ) u_timeout_timer (
        .clk      (clk),
        .rst      (rst),
        .load     ((state_q == StDelay) && delay_done),
        .load_val (TO_W'(TIMEOUT_TICKS)),
        .run      (state_q == StLight),
        .done     (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Round FSM with registered outputs; leds_on doubles as the latched light flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            leds_on <= 1'b0;
            right   <= 1'b0;
            winrnd  <= 1'b0;
            tie     <= 1'b0;
        end else begin
            winrnd <= 1'b0;
            tie    <= 1'b0;
            if (game_over) begin
                // Game win freezes everything until reset, ahead of any push.
                state_q <= StHalt;
                leds_on <= 1'b0;
                right   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (!any_push) begin
                            state_q <= StDelay;
                            leds_on <= 1'b0;
                        end
                    end
                    StDelay: begin
                        if (any_push) begin
                            state_q <= StScore;
                            if (both_push) begin
                                tie <= 1'b1;
                            end else begin
                                winrnd <= 1'b1;
                                right  <= pbr;
                            end
                        end else if (delay_done) begin
                            state_q <= StLight;
                            leds_on <= 1'b1;
                        end
                    end
                    StLight: begin
                        if (any_push) begin
                            state_q <= StScore;
                            if (both_push) begin
                                tie <= 1'b1;
                            end else begin
                                winrnd <= 1'b1;
                                right  <= pbr;
                            end
                        end else if (timeout) begin
                            state_q <= StScore;
                            tie     <= 1'b1;
                        end
                    end
                    StScore: begin
                        state_q <= StIdle;
                    end
                    StHalt: begin
                        state_q <= StHalt;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
